// File: rtl/ctrl_sequencer.sv
`default_nettype none
// =============================================================================
// ctrl_sequencer : registered RV32I/CSR/MRET decoder with memory-wait and
//                  lw.postinc sequencing. Rev 1.0. Optional macro: CTRL_POSTINC_EN
// =============================================================================
module ctrl_sequencer #(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inst_valid,
  output logic               inst_ready,
  input  logic [31:0]        inst,
  input  logic               br_taken,
  input  logic               mem_done,
  output logic               ctrl_valid,
  output logic [ALUOP_W-1:0] aluop,
  output logic               rf_en,
  output logic               rf_wsel,
  output logic               sel_a,
  output logic               sel_b,
  output logic               rd_en,
  output logic               wr_en,
  output logic [1:0]         wb_sel,
  output logic [2:0]         mem_acc_mode,
  output logic [2:0]         br_type,
  output logic               br_take,
  output logic               csr_rd,
  output logic               csr_wr,
  output logic               is_mret,
  output logic               illegal,
  output logic               mem_err
);

  localparam int                CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(10);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
`ifdef CTRL_POSTINC_EN
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
`endif
  localparam logic [31:0] INST_MRET = 32'h30200073;

  typedef enum logic [1:0] {
    S_DEC  = 2'd0,
    S_MEM  = 2'd1,
    S_PINC = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [ALUOP_W-1:0] aluop;
    logic               rf_en;
    logic               sel_a;
    logic               sel_b;
    logic               rd_en;
    logic               wr_en;
    logic [1:0]         wb_sel;
    logic [2:0]         mem_mode;
    logic [2:0]         br_type;
    logic               is_br;
    logic               jump;
    logic               csr_rd;
    logic               csr_wr;
    logic               is_mret;
    logic               illegal;
  } bundle_t;

  localparam bundle_t IDLE = '{valid: 1'b0, aluop: ALU_ADD, rf_en: 1'b0, sel_a: 1'b0,
                               sel_b: 1'b0, rd_en: 1'b0, wr_en: 1'b0, wb_sel: 2'b01,
                               mem_mode: 3'b111, br_type: 3'b111, is_br: 1'b0,
                               jump: 1'b0, csr_rd: 1'b0, csr_wr: 1'b0, is_mret: 1'b0,
                               illegal: 1'b0};

  state_t           state_q, state_d;
  bundle_t          bundle_q, bundle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;
`ifdef CTRL_POSTINC_EN
  logic             postinc_q, postinc_d;
  logic             rf_wsel_q, rf_wsel_d;
  logic             dec_pinc;
`endif

  bundle_t    dec;
  logic       dec_mem;
  logic       bad;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  function automatic logic [ALUOP_W-1:0] f3_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec       = IDLE;
    dec.valid = 1'b1;
    dec_mem   = 1'b0;
    bad       = 1'b0;
`ifdef CTRL_POSTINC_EN
    dec_pinc  = 1'b0;
`endif
    case (opcode)
      OPC_LUI: begin
        dec.rf_en = 1'b1; dec.sel_b = 1'b1; dec.aluop = ALU_LUI;
      end
      OPC_AUIPC: begin
        dec.rf_en = 1'b1; dec.sel_b = 1'b1;
      end
      OPC_JAL: begin
        dec.rf_en = 1'b1; dec.sel_b = 1'b1; dec.jump = 1'b1; dec.wb_sel = 2'b00;
      end
      OPC_JALR: begin
        bad = (funct3 != 3'b000);
        dec.rf_en = 1'b1; dec.sel_a = 1'b1; dec.sel_b = 1'b1;
        dec.jump = 1'b1; dec.wb_sel = 2'b00;
      end
      OPC_BRANCH: begin
        bad = (funct3 == 3'b010) || (funct3 == 3'b011);
        dec.is_br = 1'b1; dec.br_type = funct3; dec.sel_b = 1'b1;
      end
      OPC_LOAD: begin
        dec.rd_en = 1'b1; dec.sel_a = 1'b1; dec.sel_b = 1'b1;
        dec.wb_sel = 2'b10; dec_mem = 1'b1;
        // unsigned loads are renumbered into the compact access-mode code
        case (funct3)
          3'b000:  dec.mem_mode = 3'b000;
          3'b001:  dec.mem_mode = 3'b001;
          3'b010:  dec.mem_mode = 3'b010;
          3'b100:  dec.mem_mode = 3'b011;
          3'b101:  dec.mem_mode = 3'b100;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        bad = (funct3 >= 3'b011);
        dec.wr_en = 1'b1; dec.sel_a = 1'b1; dec.sel_b = 1'b1;
        dec.mem_mode = funct3; dec_mem = 1'b1;
      end
      OPC_OPIMM: begin
        dec.rf_en = 1'b1; dec.sel_a = 1'b1; dec.sel_b = 1'b1;
        dec.aluop = f3_alu(funct3);
        if (funct3 == 3'b001) begin
          bad = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000) dec.aluop = ALU_SRA;
          else bad = (funct7 != 7'b0000000);
        end
      end
      OPC_OP: begin
        dec.rf_en = 1'b1; dec.sel_a = 1'b1;
        dec.aluop = f3_alu(funct3);
        if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) dec.aluop = ALU_SUB;
          else if (funct3 == 3'b101) dec.aluop = ALU_SRA;
          else bad = 1'b1;
        end else begin
          bad = (funct7 != 7'b0000000);
        end
      end
      OPC_FENCE: begin
        bad = (funct3 != 3'b000);
      end
      OPC_SYSTEM: begin
        if (funct3 == 3'b000) begin
          if (inst == INST_MRET) dec.is_mret = 1'b1;
          else bad = 1'b1;
        end else if (funct3 == 3'b100) begin
          bad = 1'b1;
        end else begin
          dec.csr_rd = 1'b1; dec.csr_wr = 1'b1; dec.rf_en = 1'b1;
          dec.wb_sel = 2'b11; dec.sel_a = 1'b1; dec.sel_b = funct3[2];
        end
      end
`ifdef CTRL_POSTINC_EN
      OPC_CUSTOM0: begin
        bad = (funct3 != 3'b010);
        dec.rd_en = 1'b1; dec.sel_a = 1'b1; dec.sel_b = 1'b1;
        dec.wb_sel = 2'b10; dec.mem_mode = 3'b010;
        dec_mem = 1'b1; dec_pinc = 1'b1;
      end
`endif
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec         = IDLE;
      dec.illegal = 1'b1;
      dec_mem     = 1'b0;
`ifdef CTRL_POSTINC_EN
      dec_pinc    = 1'b0;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bundle_d  = IDLE;
    cnt_d     = '0;
    mem_err_d = 1'b0;
`ifdef CTRL_POSTINC_EN
    postinc_d = 1'b0;
    rf_wsel_d = 1'b0;
`endif
    case (state_q)
      S_DEC: begin
        if (inst_valid) begin
          bundle_d = dec;
          if (dec_mem) state_d = S_MEM;
`ifdef CTRL_POSTINC_EN
          postinc_d = dec_pinc;
`endif
        end
      end
      S_MEM: begin
        bundle_d = bundle_q;
        cnt_d    = cnt_q + CNT_W'(1);
`ifdef CTRL_POSTINC_EN
        postinc_d = postinc_q;
`endif
        // completion takes priority over a timeout landing in the same cycle
        if (mem_done) begin
          bundle_d = IDLE;
          cnt_d    = '0;
          state_d  = S_DEC;
`ifdef CTRL_POSTINC_EN
          postinc_d = 1'b0;
          if (postinc_q) begin
            state_d        = S_PINC;
            rf_wsel_d      = 1'b1;
            bundle_d.valid = 1'b1;
            bundle_d.rf_en = 1'b1;
            bundle_d.sel_a = 1'b1;
            bundle_d.sel_b = 1'b1;
          end
`endif
        end else if (cnt_q == CNT_LAST) begin
          bundle_d  = IDLE;
          cnt_d     = '0;
          state_d   = S_ERR;
          mem_err_d = 1'b1;
`ifdef CTRL_POSTINC_EN
          postinc_d = 1'b0;
`endif
        end
      end
`ifdef CTRL_POSTINC_EN
      S_PINC:  state_d = S_DEC;
`endif
      S_ERR:   state_d = S_DEC;
      default: state_d = S_DEC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_DEC;
      bundle_q  <= IDLE;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
`ifdef CTRL_POSTINC_EN
      postinc_q <= 1'b0;
      rf_wsel_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bundle_q  <= bundle_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
`ifdef CTRL_POSTINC_EN
      postinc_q <= postinc_d;
      rf_wsel_q <= rf_wsel_d;
`endif
    end
  end

  assign inst_ready   = (state_q == S_DEC);
  assign ctrl_valid   = bundle_q.valid;
  assign aluop        = bundle_q.aluop;
  // load data is written back in the cycle memory reports completion
  assign rf_en        = bundle_q.rf_en | ((state_q == S_MEM) & mem_done & bundle_q.rd_en);
  assign sel_a        = bundle_q.sel_a;
  assign sel_b        = bundle_q.sel_b;
  assign rd_en        = bundle_q.rd_en;
  assign wr_en        = bundle_q.wr_en;
  assign wb_sel       = bundle_q.wb_sel;
  assign mem_acc_mode = bundle_q.mem_mode;
  assign br_type      = bundle_q.br_type;
  assign br_take      = bundle_q.valid & (bundle_q.jump | (bundle_q.is_br & br_taken));
  assign csr_rd       = bundle_q.csr_rd;
  assign csr_wr       = bundle_q.csr_wr;
  assign is_mret      = bundle_q.is_mret;
  assign illegal      = bundle_q.illegal;
  assign mem_err      = mem_err_q;
`ifdef CTRL_POSTINC_EN
  assign rf_wsel      = rf_wsel_q;
`else
  assign rf_wsel      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// =============================================================================
// tb_ctrl_sequencer : directed scoreboard bench for ctrl_sequencer. Rev 1.0
// =============================================================================
module tb_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid = 1'b0;
  logic [31:0] inst = 32'h0;
  logic        br_taken = 1'b0;
  logic        mem_done = 1'b0;
  logic        inst_ready, ctrl_valid, rf_en, rf_wsel, sel_a, sel_b, rd_en, wr_en;
  logic [3:0]  aluop;
  logic [1:0]  wb_sel;
  logic [2:0]  mem_acc_mode, br_type;
  logic        br_take, csr_rd, csr_wr, is_mret, illegal, mem_err;

  ctrl_sequencer #(.ALUOP_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .br_taken(br_taken), .mem_done(mem_done), .ctrl_valid(ctrl_valid),
    .aluop(aluop), .rf_en(rf_en), .rf_wsel(rf_wsel), .sel_a(sel_a), .sel_b(sel_b),
    .rd_en(rd_en), .wr_en(wr_en), .wb_sel(wb_sel), .mem_acc_mode(mem_acc_mode),
    .br_type(br_type), .br_take(br_take), .csr_rd(csr_rd), .csr_wr(csr_wr),
    .is_mret(is_mret), .illegal(illegal), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  localparam int F_VALID = 0,  F_ALUOP = 1,  F_RFEN  = 2,  F_WSEL  = 3,  F_SELA = 4;
  localparam int F_SELB  = 5,  F_RDEN  = 6,  F_WREN  = 7,  F_WBSEL = 8,  F_MODE = 9;
  localparam int F_BRTYP = 10, F_BRTK  = 11, F_CSRRD = 12, F_CSRWR = 13, F_MRET = 14;
  localparam int F_ILL   = 15, F_MERR  = 16, F_READY = 17;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_LUI   = 32'h000010B7;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_BEQ   = 32'h00208063;
  localparam logic [31:0] I_JAL   = 32'h000000EF;
  localparam logic [31:0] I_MRET  = 32'h30200073;
  localparam logic [31:0] I_CSRRW = 32'h300110F3;
  localparam logic [31:0] I_SD    = 32'h0020B023;
  localparam logic [31:0] I_LD    = 32'h0000B283;
  localparam logic [31:0] I_L110  = 32'h0000E283;
  localparam logic [31:0] I_MUL   = 32'h022081B3;
  localparam logic [31:0] I_ZERO  = 32'h00000000;
  localparam logic [31:0] I_PINC  = 32'h0040A28B;

  typedef struct {
    string      tag;
    int         fld;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [3:0] field(input int f);
    logic [3:0] v;
    v = 4'h0;
    case (f)
      F_VALID: v = {3'b0, ctrl_valid};
      F_ALUOP: v = aluop;
      F_RFEN:  v = {3'b0, rf_en};
      F_WSEL:  v = {3'b0, rf_wsel};
      F_SELA:  v = {3'b0, sel_a};
      F_SELB:  v = {3'b0, sel_b};
      F_RDEN:  v = {3'b0, rd_en};
      F_WREN:  v = {3'b0, wr_en};
      F_WBSEL: v = {2'b0, wb_sel};
      F_MODE:  v = {1'b0, mem_acc_mode};
      F_BRTYP: v = {1'b0, br_type};
      F_BRTK:  v = {3'b0, br_take};
      F_CSRRD: v = {3'b0, csr_rd};
      F_CSRWR: v = {3'b0, csr_wr};
      F_MRET:  v = {3'b0, is_mret};
      F_ILL:   v = {3'b0, illegal};
      F_MERR:  v = {3'b0, mem_err};
      F_READY: v = {3'b0, inst_ready};
      default: v = 4'hx;
    endcase
    return v;
  endfunction

  task automatic push(input string tag, input int f, input logic [3:0] v);
    exp_t e;
    e.tag = tag;
    e.fld = f;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t       e;
    logic [3:0] obs;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = field(e.fld);
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic accept(input logic [31:0] w);
    inst       = w;
    inst_valid = 1'b1;
    next();
    inst_valid = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #2;
    push("rst_valid", F_VALID, 4'd0); push("rst_ready", F_READY, 4'd1);
    push("rst_wbsel", F_WBSEL, 4'd1); push("rst_mode", F_MODE, 4'd7);
    push("rst_brtype", F_BRTYP, 4'd7); push("rst_aluop", F_ALUOP, 4'd0);
    push("rst_rfen", F_RFEN, 4'd0); push("rst_merr", F_MERR, 4'd0);
    push("rst_ill", F_ILL, 4'd0); push("rst_brtake", F_BRTK, 4'd0);
    push("rst_wsel", F_WSEL, 4'd0);
    check();
    rst_n = 1'b1;

    // ADD: latency 1, bundle held one cycle
    accept(I_ADD);
    push("add_valid", F_VALID, 4'd1); push("add_aluop", F_ALUOP, 4'd0);
    push("add_rfen", F_RFEN, 4'd1); push("add_wbsel", F_WBSEL, 4'd1);
    push("add_ready", F_READY, 4'd1); push("add_sela", F_SELA, 4'd1);
    push("add_selb", F_SELB, 4'd0); push("add_mode", F_MODE, 4'd7);
    check();
    next();
    push("add_drop_valid", F_VALID, 4'd0); push("add_drop_rfen", F_RFEN, 4'd0);
    check();

    // back-to-back ADD then LUI
    inst = I_ADD; inst_valid = 1'b1;
    next();
    push("b2b_ready", F_READY, 4'd1); push("b2b_aluop0", F_ALUOP, 4'd0);
    check();
    inst = I_LUI;
    next();
    inst_valid = 1'b0;
    push("b2b_lui_aluop", F_ALUOP, 4'hA); push("b2b_lui_rfen", F_RFEN, 4'd1);
    push("b2b_lui_valid", F_VALID, 4'd1);
    check();
    next();

    // LW with mem_done in the third cycle
    accept(I_LW);
    push("lw_ready1", F_READY, 4'd0); push("lw_valid", F_VALID, 4'd1);
    push("lw_rden", F_RDEN, 4'd1); push("lw_mode", F_MODE, 4'd2);
    push("lw_rfen_wait", F_RFEN, 4'd0); push("lw_aluop", F_ALUOP, 4'd0);
    check();
    next();
    push("lw_ready2", F_READY, 4'd0); push("lw_rfen_wait2", F_RFEN, 4'd0);
    check();
    next();
    mem_done = 1'b1;
    push("lw_ready3", F_READY, 4'd0); push("lw_wb_rfen", F_RFEN, 4'd1);
    push("lw_wb_sel", F_WBSEL, 4'd2); push("lw_wb_valid", F_VALID, 4'd1);
    check();
    next();
    mem_done = 1'b0;
    push("lw_after_ready", F_READY, 4'd1); push("lw_after_rden", F_RDEN, 4'd0);
    push("lw_after_rfen", F_RFEN, 4'd0); push("lw_after_valid", F_VALID, 4'd0);
    check();

    // SW timeout
    accept(I_SW);
    push("sw_wren", F_WREN, 4'd1); push("sw_ready", F_READY, 4'd0);
    push("sw_mode", F_MODE, 4'd2);
    check();
    repeat (14) next();
    push("to_c15_merr", F_MERR, 4'd0); push("to_c15_ready", F_READY, 4'd0);
    push("to_c15_wren", F_WREN, 4'd1);
    check();
    next();
    push("to_merr", F_MERR, 4'd1); push("to_err_ready", F_READY, 4'd0);
    push("to_err_valid", F_VALID, 4'd0); push("to_err_wren", F_WREN, 4'd0);
    push("to_err_rfen", F_RFEN, 4'd0);
    check();
    next();
    push("to_after_merr", F_MERR, 4'd0); push("to_after_ready", F_READY, 4'd1);
    check();

    // SW with mem_done on cycle 15: completion wins
    accept(I_SW);
    repeat (14) next();
    mem_done = 1'b1;
    push("race_merr", F_MERR, 4'd0); push("race_ready", F_READY, 4'd0);
    check();
    next();
    mem_done = 1'b0;
    push("race_after_merr", F_MERR, 4'd0); push("race_after_ready", F_READY, 4'd1);
    push("race_after_wren", F_WREN, 4'd0);
    check();
    next();
    push("race_late_merr", F_MERR, 4'd0);
    check();

    // BEQ: br_take follows br_taken only while the bundle is valid
    accept(I_BEQ);
    br_taken = 1'b1;
    push("beq_take", F_BRTK, 4'd1); push("beq_type", F_BRTYP, 4'd0);
    push("beq_rfen", F_RFEN, 4'd0); push("beq_valid", F_VALID, 4'd1);
    check();
    br_taken = 1'b0;
    push("beq_nottaken", F_BRTK, 4'd0);
    check();
    next();
    br_taken = 1'b1;
    push("beq_stale", F_BRTK, 4'd0);
    check();
    br_taken = 1'b0;

    accept(I_JAL);
    push("jal_take", F_BRTK, 4'd1); push("jal_wbsel", F_WBSEL, 4'd0);
    push("jal_rfen", F_RFEN, 4'd1);
    check();

    accept(I_MRET);
    push("mret_flag", F_MRET, 4'd1); push("mret_rfen", F_RFEN, 4'd0);
    push("mret_valid", F_VALID, 4'd1); push("mret_csr", F_CSRRD, 4'd0);
    check();

    accept(I_CSRRW);
    push("csr_rd", F_CSRRD, 4'd1); push("csr_wr", F_CSRWR, 4'd1);
    push("csr_wbsel", F_WBSEL, 4'd3); push("csr_rfen", F_RFEN, 4'd1);
    check();

    // illegal encodings
    accept(I_SD);
    push("sd_ill", F_ILL, 4'd1); push("sd_wren", F_WREN, 4'd0);
    push("sd_rfen", F_RFEN, 4'd0); push("sd_ready", F_READY, 4'd1);
    check();
    next();
    push("ill_pulse_end", F_ILL, 4'd0);
    check();
    accept(I_LD);
    push("ld_ill", F_ILL, 4'd1); push("ld_rden", F_RDEN, 4'd0);
    check();
    accept(I_L110);
    push("l110_ill", F_ILL, 4'd1); push("l110_ready", F_READY, 4'd1);
    check();
    accept(I_MUL);
    push("mul_ill", F_ILL, 4'd1); push("mul_rfen", F_RFEN, 4'd0);
    check();
    accept(I_ZERO);
    push("zero_ill", F_ILL, 4'd1);
    check();

    // lw.postinc
    accept(I_PINC);
`ifdef CTRL_POSTINC_EN
    push("pinc_rden", F_RDEN, 4'd1); push("pinc_ready", F_READY, 4'd0);
    push("pinc_mode", F_MODE, 4'd2);
    check();
    next();
    mem_done = 1'b1;
    push("pinc_wb_rfen", F_RFEN, 4'd1); push("pinc_wb_sel", F_WBSEL, 4'd2);
    push("pinc_wb_wsel", F_WSEL, 4'd0);
    check();
    next();
    mem_done = 1'b0;
    push("pinc_upd_rfen", F_RFEN, 4'd1); push("pinc_upd_wsel", F_WSEL, 4'd1);
    push("pinc_upd_aluop", F_ALUOP, 4'd0); push("pinc_upd_wbsel", F_WBSEL, 4'd1);
    push("pinc_upd_sela", F_SELA, 4'd1); push("pinc_upd_selb", F_SELB, 4'd1);
    push("pinc_upd_rden", F_RDEN, 4'd0); push("pinc_upd_ready", F_READY, 4'd0);
    check();
    next();
    push("pinc_end_ready", F_READY, 4'd1); push("pinc_end_wsel", F_WSEL, 4'd0);
    check();
`else
    push("pinc_off_ill", F_ILL, 4'd1); push("pinc_off_rden", F_RDEN, 4'd0);
    push("pinc_off_ready", F_READY, 4'd1); push("pinc_off_wsel", F_WSEL, 4'd0);
    check();
`endif

    // asynchronous reset during S_MEM
    accept(I_LW);
    next();
    rst_n    = 1'b0;
    mem_done = 1'b1;
    push("arst_valid", F_VALID, 4'd0); push("arst_ready", F_READY, 4'd1);
    push("arst_rden", F_RDEN, 4'd0); push("arst_rfen", F_RFEN, 4'd0);
    push("arst_mode", F_MODE, 4'd7); push("arst_wbsel", F_WBSEL, 4'd1);
    check();
    next();
    mem_done = 1'b0;
    rst_n    = 1'b1;
    accept(I_ADD);
    push("post_rst_valid", F_VALID, 4'd1); push("post_rst_rfen", F_RFEN, 4'd1);
    push("post_rst_aluop", F_ALUOP, 4'd0); push("post_rst_ready", F_READY, 4'd1);
    check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
